// File: rtl/io_filter_pkg.sv
// Shared constants and helpers for the synchronising input filter family.
package io_filter_pkg;
    localparam int   I2C_SYNC_STAGES = 2;
    localparam int   I2C_FILTER_LEN  = 3;
    localparam logic I2C_IDLE_LEVEL  = 1'b1;

    localparam int CH_SCL = 0;
    localparam int CH_SDA = 1;

    // Counter only needs to reach len-1; keep at least one bit for len <= 2.
    function automatic int cnt_width(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction
endpackage

// File: rtl/io_filter_ch.sv
// One channel: synchroniser chain, consecutive-sample spike filter and edge/glitch pulses.
module io_filter_ch
    import io_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int   FILTER_LEN  = I2C_FILTER_LEN,
    parameter logic RESET_VAL   = I2C_IDLE_LEVEL
) (
    input  logic clk_sync,
    input  logic reset_n,
    input  logic sample_en,
    input  logic bypass,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic glitch
);
    localparam int            CW      = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   out_nxt, rise_nxt, fall_nxt, glitch_nxt;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_nxt    = cnt;
        out_nxt    = out;
        glitch_nxt = 1'b0;
        if (bypass) begin
            out_nxt = sync;
            cnt_nxt = '0;
        end else if (sample_en) begin
            if (sync == out) begin
                // A run that ended before reaching FILTER_LEN was a spike.
                if (cnt != '0) begin
                    cnt_nxt    = '0;
                    glitch_nxt = 1'b1;
                end
            end else if (cnt == CNT_MAX) begin
                out_nxt = sync;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        rise_nxt = ~out & out_nxt;
        fall_nxt = out & ~out_nxt;
    end

    always_ff @(posedge clk_sync or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            out    <= RESET_VAL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            out    <= out_nxt;
            cnt    <= cnt_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            glitch <= glitch_nxt;
        end
    end
endmodule

// File: rtl/io_sync_filter_multi.sv
// NUM_CH independent synchronise-and-filter channels sharing one sample strobe and bypass.
module io_sync_filter_multi
    import io_filter_pkg::*;
#(
    parameter int   NUM_CH      = 2,
    parameter int   SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int   FILTER_LEN  = I2C_FILTER_LEN,
    parameter logic RESET_VAL   = I2C_IDLE_LEVEL
) (
    input  logic              clk_sync,
    input  logic              reset_n,
    input  logic              sample_en,
    input  logic              bypass,
    input  logic [NUM_CH-1:0] in,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] glitch
);
    if (NUM_CH < 1)      begin : g_bad_num_ch  $error("NUM_CH must be >= 1");      end
    if (SYNC_STAGES < 2) begin : g_bad_sync    $error("SYNC_STAGES must be >= 2"); end
    if (FILTER_LEN < 1)  begin : g_bad_filter  $error("FILTER_LEN must be >= 1");  end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        io_filter_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL)
        ) u_ch (
            .clk_sync (clk_sync),
            .reset_n  (reset_n),
            .sample_en(sample_en),
            .bypass   (bypass),
            .in       (in[gi]),
            .out      (out[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi]),
            .glitch   (glitch[gi])
        );
    end
endmodule
